microwave_timer: RTL and testbench



---
 rtl/microwave_pkg.sv | 24 ++
 rtl/microwave_sec2bcd.sv | 50 +++++
 rtl/microwave_timer.sv | 103 ++++++++++
 tb/tb_microwave_timer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/microwave_pkg.sv
// rtl/microwave_pkg.sv - mode encodings and timing constants shared by the microwave blocks
package microwave_pkg;

  typedef enum logic [2:0] {
    MODE_IDLE   = 3'd0,
    MODE_SET    = 3'd1,
    MODE_RUN    = 3'd2,
    MODE_STOP   = 3'd3,
    MODE_FINISH = 3'd4
  } mode_e;

  localparam int CLK_HZ_DEFAULT = 100_000_000;
  localparam int ONE_SEC_CYCLES = CLK_HZ_DEFAULT;

  // Widen to 15 bits before the ceiling check so a large base can never wrap.
  function automatic logic [13:0] sat_add(input logic [13:0] base,
                                          input logic [14:0] step,
                                          input logic [13:0] ceiling);
    logic [14:0] sum;
    sum = {1'b0, base} + step;
    return (sum > {1'b0, ceiling}) ? ceiling : sum[13:0];
  endfunction

endpackage

// File: rtl/microwave_sec2bcd.sv
// rtl/microwave_sec2bcd.sv - registered binary seconds to mm:ss BCD digits
module microwave_sec2bcd
  import microwave_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] sec_bin,
  output logic [3:0]  min_tens,
  output logic [3:0]  min_ones,
  output logic [3:0]  sec_tens,
  output logic [3:0]  sec_ones
);

  logic [13:0] mins_w;
  logic [6:0]  mins7;
  logic [5:0]  secs6;
  logic [3:0]  min_tens_d, min_ones_d, sec_tens_d, sec_ones_d;
  logic [3:0]  min_tens_q, min_ones_q, sec_tens_q, sec_ones_q;

  // Minutes clamp at 99 so two display digits always suffice.
  always_comb begin
    mins_w     = sec_bin / 14'd60;
    mins7      = (mins_w > 14'd99) ? 7'd99 : mins_w[6:0];
    secs6      = 6'(sec_bin % 14'd60);
    min_tens_d = 4'(mins7 / 7'd10);
    min_ones_d = 4'(mins7 % 7'd10);
    sec_tens_d = 4'(secs6 / 6'd10);
    sec_ones_d = 4'(secs6 % 6'd10);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      min_tens_q <= '0;
      min_ones_q <= '0;
      sec_tens_q <= '0;
      sec_ones_q <= '0;
    end else begin
      min_tens_q <= min_tens_d;
      min_ones_q <= min_ones_d;
      sec_tens_q <= sec_tens_d;
      sec_ones_q <= sec_ones_d;
    end
  end

  assign min_tens = min_tens_q;
  assign min_ones = min_ones_q;
  assign sec_tens = sec_tens_q;
  assign sec_ones = sec_ones_q;

endmodule

// File: rtl/microwave_timer.sv
// rtl/microwave_timer.sv - run_time entry/countdown for the microwave FSM; MICROWAVE_TIMER_BCD_EN adds mm:ss BCD outputs
module microwave_timer
  import microwave_pkg::*;
#(
  parameter int CLK_HZ   = ONE_SEC_CYCLES,
  parameter int STEP_SEC = 30,
  parameter int MAX_TIME = 5999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  mode,
  input  logic        btnU,
  input  logic        btnD,
  input  logic        door,
  output logic [13:0] run_time,
  output logic        done,
  output logic        tick_1s
`ifdef MICROWAVE_TIMER_BCD_EN
  ,
  output logic [3:0]  min_tens,
  output logic [3:0]  min_ones,
  output logic [3:0]  sec_tens,
  output logic [3:0]  sec_ones
`endif
);

  localparam int              PW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0]   PRE_LAST = PW'(CLK_HZ - 1);
  localparam logic [14:0]     STEP15   = 15'(STEP_SEC);
  localparam logic [13:0]     STEP14   = 14'(STEP_SEC);
  localparam logic [13:0]     MAX14    = 14'(MAX_TIME);

  logic [PW-1:0] presc_d, presc_q;
  logic [13:0]   run_time_d, run_time_q;
  logic          done_d, done_q;
  logic          tick_d, tick_q;
  logic          tick;
  logic [13:0]   dec_w;

  assign tick = (mode == MODE_RUN) && !door && (presc_q == PRE_LAST);

  always_comb begin
    presc_d    = presc_q;
    run_time_d = run_time_q;
    done_d     = 1'b0;
    tick_d     = tick;
    dec_w      = run_time_q;
    case (mode)
      MODE_SET: begin
        presc_d = '0;
        if (btnU && !btnD)
          run_time_d = sat_add(run_time_q, STEP15, MAX14);
        else if (btnD && !btnU)
          run_time_d = (run_time_q < STEP14) ? 14'd0 : run_time_q - STEP14;
      end
      MODE_RUN: begin
        // Door open freezes the prescaler so the partial second survives.
        if (!door)
          presc_d = tick ? '0 : presc_q + 1'b1;
        dec_w      = (tick && run_time_q != 14'd0) ? run_time_q - 14'd1 : run_time_q;
        run_time_d = btnU ? sat_add(dec_w, STEP15, MAX14) : dec_w;
        done_d     = tick && (run_time_q == 14'd1) && !btnU;
      end
      MODE_STOP: begin
      end
      default: begin
        presc_d    = '0;
        run_time_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q    <= '0;
      run_time_q <= '0;
      done_q     <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      run_time_q <= run_time_d;
      done_q     <= done_d;
      tick_q     <= tick_d;
    end
  end

  assign run_time = run_time_q;
  assign done     = done_q;
  assign tick_1s  = tick_q;

`ifdef MICROWAVE_TIMER_BCD_EN
  microwave_sec2bcd u_sec2bcd (
    .clk      (clk),
    .reset    (reset),
    .sec_bin  (run_time_q),
    .min_tens (min_tens),
    .min_ones (min_ones),
    .sec_tens (sec_tens),
    .sec_ones (sec_ones)
  );
`endif

endmodule

// File: tb/tb_microwave_timer.sv
// tb/tb_microwave_timer.sv - vector table plus scoreboard sequences for microwave_timer
module tb_microwave_timer;
  import microwave_pkg::*;

  localparam int CLK_HZ = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  mode;
  logic        btnU, btnD, door;
  logic [13:0] run_time;
  logic        done, tick_1s;
`ifdef MICROWAVE_TIMER_BCD_EN
  logic [3:0]  min_tens, min_ones, sec_tens, sec_ones;
`endif

  microwave_timer #(.CLK_HZ(CLK_HZ), .STEP_SEC(30), .MAX_TIME(5999)) dut (
    .clk      (clk),
    .reset    (reset),
    .mode     (mode),
    .btnU     (btnU),
    .btnD     (btnD),
    .door     (door),
    .run_time (run_time),
    .done     (done),
    .tick_1s  (tick_1s)
`ifdef MICROWAVE_TIMER_BCD_EN
    ,
    .min_tens (min_tens),
    .min_ones (min_ones),
    .sec_tens (sec_tens),
    .sec_ones (sec_ones)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    rt;
    bit    dn;
    bit    tk;
    bit    ck_tk;
  } exp_t;

  typedef struct {
    logic [2:0] m;
    bit         u;
    bit         d;
    bit         dr;
    int         rt;
    bit         dn;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  task automatic av(input logic [2:0] m, input bit u, input bit d, input bit dr,
                    input int rt, input bit dn);
    vec_t v;
    v.m = m; v.u = u; v.d = d; v.dr = dr; v.rt = rt; v.dn = dn;
    vecs.push_back(v);
  endtask

  task automatic push_exp(input string n, input int rt, input bit dn, input bit tk, input bit ck_tk);
    exp_t e;
    e.name = n; e.rt = rt; e.dn = dn; e.tk = tk; e.ck_tk = ck_tk;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL sb_empty: DUT output with no expectation queued");
      return;
    end
    e = sb.pop_front();
    if (run_time !== 14'(e.rt) || done !== e.dn || (e.ck_tk && tick_1s !== e.tk)) begin
      fails++;
      $display("FAIL %s: got run_time=%0d done=%0b tick_1s=%0b, want run_time=%0d done=%0b tick_1s=%0b",
               e.name, run_time, done, tick_1s, e.rt, e.dn, e.tk);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read at the same point.
  task automatic cyc(input logic [2:0] m, input bit u, input bit d, input bit dr);
    mode = m; btnU = u; btnD = d; door = dr;
    @(posedge clk);
    #1;
  endtask

  task automatic run_cycles(input logic [2:0] m, input bit u, input bit d, input bit dr, input int n);
    for (int i = 0; i < n; i++) cyc(m, u, d, dr);
  endtask

  task automatic step_chk(input logic [2:0] m, input bit u, input bit d, input bit dr,
                          input string n, input int rt, input bit dn, input bit tk, input bit ck_tk);
    push_exp(n, rt, dn, tk, ck_tk);
    cyc(m, u, d, dr);
    pop_check();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; mode = MODE_IDLE; btnU = 1'b0; btnD = 1'b0; door = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    push_exp("reset_state", 0, 1'b0, 1'b0, 1'b1);
    pop_check();
    reset = 1'b0;

    av(MODE_SET,    1, 0, 0, 30, 0);
    av(MODE_SET,    0, 0, 0, 30, 0);
    av(MODE_SET,    1, 0, 0, 60, 0);
    av(MODE_SET,    1, 0, 0, 90, 0);
    av(MODE_SET,    0, 1, 0, 60, 0);
    av(MODE_SET,    1, 1, 0, 60, 0);
    av(MODE_SET,    0, 1, 0, 30, 0);
    av(MODE_SET,    0, 1, 0,  0, 0);
    av(MODE_SET,    0, 1, 0,  0, 0);
    av(MODE_SET,    1, 0, 0, 30, 0);
    av(MODE_STOP,   1, 0, 0, 30, 0);
    av(MODE_STOP,   0, 1, 0, 30, 0);
    av(MODE_RUN,    0, 1, 0, 30, 0);
    av(MODE_RUN,    1, 0, 0, 60, 0);
    av(MODE_SET,    0, 1, 0, 30, 0);
    av(3'd7,        0, 0, 0,  0, 0);
    av(MODE_SET,    1, 0, 0, 30, 0);
    av(MODE_FINISH, 0, 0, 0,  0, 0);
    av(MODE_SET,    1, 0, 0, 30, 0);
    av(MODE_IDLE,   1, 0, 0,  0, 0);
    for (int i = 0; i < vecs.size(); i++)
      step_chk(vecs[i].m, vecs[i].u, vecs[i].d, vecs[i].dr,
               $sformatf("vec%0d", i), vecs[i].rt, vecs[i].dn, 1'b0, 1'b1);

    // Floor: 30 counted down to 20, then btnD drops to 0 with no done.
    cyc(MODE_IDLE, 0, 0, 0);
    cyc(MODE_SET, 1, 0, 0);
    run_cycles(MODE_RUN, 0, 0, 0, 100);
    step_chk(MODE_STOP, 0, 0, 0, "floor_at_20", 20, 1'b0, 1'b0, 1'b1);
    step_chk(MODE_SET, 0, 1, 0, "floor_btnD", 0, 1'b0, 1'b0, 1'b1);

    // Ceiling: 200 presses saturate at 5999; count to 5990, then +30 saturates twice.
    cyc(MODE_IDLE, 0, 0, 0);
    run_cycles(MODE_SET, 1, 0, 0, 200);
    step_chk(MODE_SET, 0, 0, 0, "sat_entry", 5999, 1'b0, 1'b0, 1'b1);
    run_cycles(MODE_RUN, 0, 0, 0, 90);
    step_chk(MODE_SET, 1, 0, 0, "sat_5990_up", 5999, 1'b0, 1'b0, 1'b1);
    step_chk(MODE_SET, 1, 0, 0, "sat_again", 5999, 1'b0, 1'b0, 1'b1);

    // Countdown from 2 with done on the 1->0 edge only.
    cyc(MODE_IDLE, 0, 0, 0);
    cyc(MODE_SET, 1, 0, 0);
    run_cycles(MODE_RUN, 0, 0, 0, 280);
    for (int i = 1; i <= 20; i++)
      step_chk(MODE_RUN, 0, 0, 0, $sformatf("count_c%0d", i),
               (i < 10) ? 2 : ((i < 20) ? 1 : 0), (i == 20), (i == 10 || i == 20), 1'b1);
    for (int i = 1; i <= 15; i++)
      step_chk(MODE_RUN, 0, 0, 0, $sformatf("count_hold%0d", i), 0, 1'b0, 1'b0, 1'b0);

    // Pause via STOP with the prescaler at 6, then via an open door.
    cyc(MODE_IDLE, 0, 0, 0);
    cyc(MODE_SET, 1, 0, 0);
    run_cycles(MODE_RUN, 0, 0, 0, 6);
    run_cycles(MODE_STOP, 0, 0, 0, 49);
    step_chk(MODE_STOP, 0, 0, 0, "stop_hold", 30, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++)
      step_chk(MODE_RUN, 0, 0, 0, $sformatf("stop_resume%0d", i),
               (i < 4) ? 30 : 29, 1'b0, (i == 4), 1'b1);
    run_cycles(MODE_RUN, 0, 0, 0, 6);
    run_cycles(MODE_RUN, 0, 0, 1, 49);
    step_chk(MODE_RUN, 0, 0, 1, "door_hold", 29, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++)
      step_chk(MODE_RUN, 0, 0, 0, $sformatf("door_resume%0d", i),
               (i < 4) ? 29 : 28, 1'b0, (i == 4), 1'b1);

    // Quick-add landing on the tick: 100 - 1 + 30.
    cyc(MODE_IDLE, 0, 0, 0);
    run_cycles(MODE_SET, 1, 0, 0, 4);
    run_cycles(MODE_RUN, 0, 0, 0, 200);
    run_cycles(MODE_RUN, 0, 0, 0, 9);
    step_chk(MODE_STOP, 0, 0, 0, "pre_tick_100", 100, 1'b0, 1'b0, 1'b1);
    cyc(MODE_IDLE, 0, 0, 0);
    run_cycles(MODE_SET, 1, 0, 0, 4);
    run_cycles(MODE_RUN, 0, 0, 0, 209);
    step_chk(MODE_RUN, 1, 0, 0, "tick_plus_btnU", 129, 1'b0, 1'b1, 1'b1);

    // FINISH clears 45 without done.
    cyc(MODE_IDLE, 0, 0, 0);
    run_cycles(MODE_SET, 1, 0, 0, 2);
    run_cycles(MODE_RUN, 0, 0, 0, 150);
    step_chk(MODE_FINISH, 0, 0, 0, "finish_clear", 0, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset mid-RUN, checked before the next clock edge.
    cyc(MODE_SET, 1, 0, 0);
    run_cycles(MODE_RUN, 0, 0, 0, 5);
    reset = 1'b1;
    #2;
    push_exp("async_reset", 0, 1'b0, 1'b0, 1'b1);
    pop_check();
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 1; i <= 10; i++)
      step_chk(MODE_RUN, 0, 0, 0, $sformatf("presc_cleared%0d", i), 0, 1'b0, (i == 10), 1'b1);

`ifdef MICROWAVE_TIMER_BCD_EN
    cyc(MODE_IDLE, 0, 0, 0);
    run_cycles(MODE_SET, 1, 0, 0, 26);
    run_cycles(MODE_RUN, 0, 0, 0, 260);
    cyc(MODE_STOP, 0, 0, 0);
    tests++;
    if (run_time !== 14'd754 || min_tens !== 4'd1 || min_ones !== 4'd2 ||
        sec_tens !== 4'd3 || sec_ones !== 4'd4) begin
      fails++;
      $display("FAIL bcd_754: got run_time=%0d digits=%0d%0d:%0d%0d, want run_time=754 digits=12:34",
               run_time, min_tens, min_ones, sec_tens, sec_ones);
    end
`endif

    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_leftover: got %0d queued expectations, want 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
